// File: rtl/run_stuff_pkg.sv
`default_nettype none
// ============================================================================
// Module   : run_stuff_pkg
// Purpose  : Shared encodings and defaults for the run-limited serial link
//            (stuffing transmitter and destuffing receiver).
// Revision : 1.0
// ============================================================================
package run_stuff_pkg;

    localparam int c_default_data_w  = 8;
    localparam int c_default_max_run = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STUFF = 2'd2
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/run_stuff_tx_run_counter.sv
`default_nettype none
// ============================================================================
// Module   : run_counter
// Purpose  : Tracks the run of identical emitted bits and flags when the bit
//            being emitted completes a MAX_RUN run.
// Revision : 1.0
// ============================================================================
module run_counter
    import run_stuff_pkg::*;
#(
    parameter int MAX_RUN = c_default_max_run,
    parameter int CNT_W   = $clog2(MAX_RUN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             en,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             stuff_due,
    output logic             last_bit
);

    localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_RUN);

    logic [CNT_W-1:0] r_count;
    logic             r_last;
    logic [CNT_W-1:0] w_next;

    // An empty count or a changed bit starts a fresh run; otherwise extend and saturate.
    always_comb begin
        w_next = CNT_W'(1);
        if ((r_count != '0) && (bit_in == r_last)) begin
            w_next = (r_count == c_max) ? c_max : r_count + 1'b1;
        end
    end

    assign stuff_due = en && (w_next == c_max);
    assign count     = r_count;
    assign last_bit  = r_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_last  <= 1'b0;
        end else if (clear) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_next;
            r_last  <= bit_in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/run_stuff_tx.sv
`default_nettype none
// ============================================================================
// Module   : run_stuff_tx
// Purpose  : LSB-first serialiser that inserts a complemented stuff bit after
//            every MAX_RUN identical bits on the line.
// Revision : 1.0
// ============================================================================
module run_stuff_tx
    import run_stuff_pkg::*;
#(
    parameter int DATA_W  = c_default_data_w,
    parameter int MAX_RUN = c_default_max_run
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_en,
    output logic              tx_stuff,
    output logic              busy
);

    localparam int               IDX_W      = $clog2(DATA_W);
    localparam int               CNT_W      = $clog2(MAX_RUN + 1);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DATA_W - 1);

    tx_state_t         r_state;
    logic [DATA_W-1:0] r_sreg;
    logic [IDX_W-1:0]  r_idx;
    logic              r_final_stuff;

    logic              w_line_bit;
    logic              w_cnt_en;
    logic              w_cnt_clear;
    logic              w_stuff_due;
    logic              w_last_bit;
    logic [CNT_W-1:0]  w_run_cnt;
    logic              w_word_end;
    logic              w_load;

    assign w_line_bit  = (r_state == ST_STUFF) ? ~w_last_bit : r_sreg[0];
    assign w_cnt_en    = (r_state == ST_SHIFT) || (r_state == ST_STUFF);
    assign w_cnt_clear = (r_state == ST_IDLE) && (w_run_cnt != '0);

    run_counter #(
        .MAX_RUN (MAX_RUN),
        .CNT_W   (CNT_W)
    ) u_run_counter (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (w_line_bit),
        .en        (w_cnt_en),
        .clear     (w_cnt_clear),
        .count     (w_run_cnt),
        .stuff_due (w_stuff_due),
        .last_bit  (w_last_bit)
    );

    // Final cycle of a word: accepting here gives gap-free back-to-back words.
    assign w_word_end = ((r_state == ST_SHIFT) && (r_idx == c_last_idx) && !w_stuff_due)
                     || ((r_state == ST_STUFF) && r_final_stuff);
    assign in_ready   = rst && ((r_state == ST_IDLE) || w_word_end);
    assign w_load     = in_valid && in_ready;
    assign busy       = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_sreg        <= '0;
            r_idx         <= '0;
            r_final_stuff <= 1'b0;
            tx_bit        <= 1'b0;
            tx_en         <= 1'b0;
            tx_stuff      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    tx_en    <= 1'b0;
                    tx_stuff <= 1'b0;
                end
                ST_SHIFT: begin
                    tx_bit   <= r_sreg[0];
                    tx_en    <= 1'b1;
                    tx_stuff <= 1'b0;
                    r_sreg   <= r_sreg >> 1;
                    if (w_stuff_due) begin
                        r_state       <= ST_STUFF;
                        r_final_stuff <= (r_idx == c_last_idx);
                        if (r_idx != c_last_idx) begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else if (r_idx == c_last_idx) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_STUFF: begin
                    tx_bit   <= ~w_last_bit;
                    tx_en    <= 1'b1;
                    tx_stuff <= 1'b1;
                    r_state  <= r_final_stuff ? ST_IDLE : ST_SHIFT;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    tx_en    <= 1'b0;
                    tx_stuff <= 1'b0;
                end
            endcase
            // A handshake overrides the end-of-word transition to IDLE.
            if (w_load) begin
                r_sreg  <= in_data;
                r_idx   <= '0;
                r_state <= ST_SHIFT;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/run_stuff_tx.md
Name: run_stuff_tx

Overview:
- Serial transmitter for the run-limited bit stream consumed by the run-length detector FSM.
- Takes parallel words over a valid/ready handshake and shifts them out one bit per clock, LSB first.
- After every MAX_RUN consecutive identical emitted bits it inserts one complemented stuff bit, so the line never carries a run longer than MAX_RUN.
- Sits between the byte source and the serial line; the receive side detects and removes the stuff bits.

Parameters:
- DATA_W, 8, word width in bits (>=2).
- MAX_RUN, 2, longest permitted run of identical bits on tx_bit (>=1); the stuff bit follows the MAX_RUN-th identical bit.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- in_valid  input  1  in_data is valid.
- in_data  input  DATA_W  word to send.
- in_ready  output  1  block accepts in_data this cycle.
- tx_bit  output  1  serial line bit, registered.
- tx_en  output  1  tx_bit carries a data or stuff bit this cycle, registered.
- tx_stuff  output  1  current tx_bit is a stuff bit (qualified by tx_en), registered.
- busy  output  1  high while a word or a pending stuff bit is in flight.

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous and active-low.
- Reset (rst=0, any time, including mid-word):
  - State goes to IDLE; shift register, bit index and run counter clear; last-bit register = 0.
  - tx_bit=0, tx_en=0, tx_stuff=0, busy=0.
  - in_ready is 0 while rst=0 and 1 in the first cycle after release.
  - A partially sent word is discarded and nothing is re-sent.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, load the word and go to SHIFT.
  - SHIFT: emit data bit[idx].
    - If the run counter reaches MAX_RUN after this bit, go to STUFF.
    - Else if idx==DATA_W-1, go to IDLE, or reload if a handshake occurs.
    - Else idx+1.
  - STUFF: emit ~last_bit with tx_stuff=1.
    - Then resume SHIFT at the next idx.
    - If the word is complete, go to IDLE, or reload on a handshake.
- Latency: handshake at rising edge N puts bit0 on tx_bit/tx_en from edge N+1.
  - Each emitted bit lasts exactly one cycle.
  - Word duration = DATA_W + number of stuff bits cycles.
- in_ready (combinational from state) is 1 in IDLE, or in the final cycle of a word. The final cycle is either:
  - SHIFT with idx==DATA_W-1 and no stuff due, or
  - STUFF following the last data bit.
  - This allows back-to-back words with zero gap cycles.
- Run counter:
  - Counts consecutive identical emitted bits, saturating at MAX_RUN.
  - A stuff bit restarts the count at 1 with the new value.
  - The count carries across back-to-back word boundaries.
  - On entering IDLE (line goes quiet), the count resets to 0 and last_bit is kept.
- A stuff bit due after the last data bit is always sent before IDLE or the next word, even when no next word exists.
- in_valid while in_ready=0 is ignored; in_data is sampled only on handshake.
- busy = (state != IDLE).
- tx_bit holds its last value while tx_en=0.

Decomposition:
- Shared package: state encoding constants (IDLE, SHIFT, STUFF) and the default DATA_W and MAX_RUN values, reused by the matching destuffing receiver.
- One natural sub-module: run_counter (bit in, enable, clear → count, stuff_due).
- Shift register and FSM stay in the top level.

Test Plan:
- Idle/reset: hold rst=0 for 3 cycles, release, and send nothing → tx_en=0, tx_bit=0, busy=0, in_ready=1.
- 0x55, MAX_RUN=2 → tx_bit 1,0,1,0,1,0,1,0 over 8 cycles starting one cycle after the handshake; tx_stuff never asserted; in_ready=1 in cycle 8.
- 0x00 → 0,0,[1],0,0,[1],0,0,[1],0,0,[1] over 12 cycles; tx_stuff high in cycles 3,6,9,12; final stuff sent before IDLE.
- Back-to-back 0xFF then 0xFF with in_valid held → 24 contiguous tx_en cycles, no gap; stuff pattern 1,1,[0] repeats across the word boundary.
- Reset at bit 4 of 0x0F → outputs zero asynchronously; the next word 0xAA starts cleanly with run count 0.
- Random words at random valid gaps (2000 words) → no run of more than MAX_RUN identical bits on tx_bit; the destuffed stream equals the input words; stuff count matches the reference model.
